// File: rtl/regfile_pkg.sv
// Shared constants and entry type for the register-file write queue.
// Holds Width, Depth, RegAddrW and the {rd, data} entry struct.
package regfile_pkg;

  localparam int Width    = 32;
  localparam int Depth    = 4;
  localparam int RegAddrW = 5;
  localparam int PtrW     = $clog2(Depth);
  localparam int CntW     = $clog2(Depth) + 1;

  typedef struct packed {
    logic [RegAddrW-1:0] rd;
    logic [Width-1:0]    data;
  } wbq_entry_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Producer handshake and register-file write port of the write queue.
// master: producer/regfile side; slave: the queue itself.
interface regfile_write_queue_if;
  import regfile_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [RegAddrW-1:0] in_rd;
  logic [Width-1:0]    in_data;
  logic                wb_stall;
  logic                RegWrite;
  logic [RegAddrW-1:0] W1;
  logic [Width-1:0]    WD1;

  modport master (
    output in_valid, in_rd, in_data, wb_stall,
    input  in_ready, RegWrite, W1, WD1
  );

  modport slave (
    input  in_valid, in_rd, in_data, wb_stall,
    output in_ready, RegWrite, W1, WD1
  );

endinterface

// File: rtl/wbq_fwd_lookup.sv
// Youngest-match search of pending writes for one read address.
// Ports: i_ent/i_vld storage, i_wptr, i_raddr -> o_hit, o_data.
module wbq_fwd_lookup
  import regfile_pkg::*;
(
  input  wbq_entry_t [Depth-1:0] i_ent,
  input  logic [Depth-1:0]       i_vld,
  input  logic [PtrW-1:0]        i_wptr,
  input  logic [RegAddrW-1:0]    i_raddr,
  output logic                   o_hit,
  output logic [Width-1:0]       o_data
);

  logic [PtrW-1:0] w_idx;

  // Walk back from the newest slot (wptr-1); first match is youngest.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int i = 1; i <= Depth; i++) begin
      w_idx = i_wptr - PtrW'(i);
      if (!o_hit && i_raddr != '0 && i_vld[w_idx] &&
          i_ent[w_idx].rd == i_raddr) begin
        o_hit  = 1'b1;
        o_data = i_ent[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order FIFO of pending register writes with read forwarding.
// Ports: clk, rst_n, bus (handshake + write port), R1/R2 -> fwd*, count.
module regfile_write_queue
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_write_queue_if.slave  bus,
  input  logic [RegAddrW-1:0]   R1,
  input  logic [RegAddrW-1:0]   R2,
  output logic                  fwd1_hit,
  output logic [Width-1:0]      fwd1_data,
  output logic                  fwd2_hit,
  output logic [Width-1:0]      fwd2_data,
  output logic [CntW-1:0]       count
);

  wbq_entry_t [Depth-1:0] r_mem;
  logic [Depth-1:0]       r_vld;
  logic [PtrW-1:0]        r_wptr;
  logic [PtrW-1:0]        r_rptr;
  logic [CntW-1:0]        r_cnt;

  logic       w_push;
  logic       w_pop;
  logic       w_empty;
  wbq_entry_t w_head;

  assign w_empty      = (r_cnt == '0);
  assign bus.in_ready = (r_cnt < CntW'(Depth));
  // rd==0 requests are handshaken but never stored.
  assign w_push       = bus.in_valid && bus.in_ready &&
                        (bus.in_rd != '0);
  assign w_pop        = bus.RegWrite;
  assign w_head       = r_mem[r_rptr];

  assign bus.RegWrite = !w_empty && !bus.wb_stall;
  assign bus.W1       = w_empty ? '0 : w_head.rd;
  assign bus.WD1      = w_empty ? '0 : w_head.data;
  assign count        = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
    end else begin
      if (w_pop) begin
        r_rptr        <= r_rptr + PtrW'(1);
        r_vld[r_rptr] <= 1'b0;
      end
      if (w_push) begin
        r_wptr        <= r_wptr + PtrW'(1);
        r_vld[r_wptr] <= 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload needs no reset; validity lives in r_vld.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{rd: bus.in_rd, data: bus.in_data};
    end
  end

  wbq_fwd_lookup u_fwd1 (
    .i_ent   (r_mem),
    .i_vld   (r_vld),
    .i_wptr  (r_wptr),
    .i_raddr (R1),
    .o_hit   (fwd1_hit),
    .o_data  (fwd1_data)
  );

  wbq_fwd_lookup u_fwd2 (
    .i_ent   (r_mem),
    .i_vld   (r_vld),
    .i_wptr  (r_wptr),
    .i_raddr (R2),
    .o_hit   (fwd2_hit),
    .o_data  (fwd2_data)
  );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue.
// Directed pushes feed an expected-write queue; a monitor checks writes.
module tb_regfile_write_queue;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [RegAddrW-1:0] R1 = '0;
  logic [RegAddrW-1:0] R2 = '0;
  logic fwd1_hit, fwd2_hit;
  logic [Width-1:0] fwd1_data, fwd2_data;
  logic [CntW-1:0] count;

  int n_chk = 0;
  int n_fail = 0;

  wbq_entry_t sb[$];

  regfile_write_queue_if bus ();

  regfile_write_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .R1        (R1),
    .R2        (R2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every write on the port must match the oldest expected one.
  initial begin
    wbq_entry_t e;
    forever begin
      @(negedge clk);
      if (bus.RegWrite === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got W1=%0d WD1=%h expected none",
                   bus.W1, bus.WD1);
        end else begin
          e = sb.pop_front();
          if (bus.W1 !== e.rd || bus.WD1 !== e.data) begin
            n_fail++;
            $display("FAIL write_order: got W1=%0d WD1=%h expected %0d %h",
                     bus.W1, bus.WD1, e.rd, e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [4:0] rd, logic [31:0] d, bit acc);
    bus.in_valid = 1'b1;
    bus.in_rd    = rd;
    bus.in_data  = d;
    if (acc && rd != 0) sb.push_back('{rd: rd, data: d});
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_rd    = '0;
    bus.in_data  = '0;
    bus.wb_stall = 1'b0;
    R1 = 5'd5;

    // Reset state
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_regwrite", 32'(bus.RegWrite), 0);
    chk("rst_w1", 32'(bus.W1), 0);
    chk("rst_wd1", bus.WD1, 0);
    chk("rst_fwd1_hit", 32'(fwd1_hit), 0);
    chk("rst_fwd1_data", fwd1_data, 0);
    chk("rst_fwd2_hit", 32'(fwd2_hit), 0);
    step();
    rst_n = 1'b1;
    step();

    // Single write, one-cycle latency
    push(5'd5, 32'hA5A5_A5A5, 1);
    chk("lat_regwrite", 32'(bus.RegWrite), 1);
    chk("lat_w1", 32'(bus.W1), 5);
    chk("lat_wd1", bus.WD1, 32'hA5A5_A5A5);
    chk("lat_fwd_popping_head", 32'(fwd1_hit), 1);
    step();
    chk("lat_count_after", 32'(count), 0);

    // Fill under stall, overflow push refused, drain in order
    bus.wb_stall = 1'b1;
    push(5'd1, 32'h11, 1);
    push(5'd2, 32'h22, 1);
    push(5'd3, 32'h33, 1);
    push(5'd4, 32'h44, 1);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("full_regwrite", 32'(bus.RegWrite), 0);
    push(5'd9, 32'h99, 0);
    chk("full_count_after_5th", 32'(count), 4);
    bus.wb_stall = 1'b0;
    #1;
    chk("drain_w1_first", 32'(bus.W1), 1);
    for (int i = 3; i >= 0; i--) begin
      step();
      chk("drain_count", 32'(count), 32'(i));
    end

    // Forwarding: youngest match wins, R=0 never hits
    bus.wb_stall = 1'b1;
    push(5'd7, 32'h1, 1);
    push(5'd8, 32'h80, 1);
    push(5'd7, 32'h2, 1);
    R1 = 5'd7;
    R2 = 5'd0;
    #1;
    chk("fwd1_hit", 32'(fwd1_hit), 1);
    chk("fwd1_data_youngest", fwd1_data, 32'h2);
    chk("fwd2_hit_r0", 32'(fwd2_hit), 0);
    chk("fwd2_data_r0", fwd2_data, 0);
    R2 = 5'd8;
    #1;
    chk("fwd2_hit_r8", 32'(fwd2_hit), 1);
    chk("fwd2_data_r8", fwd2_data, 32'h80);
    R2 = 5'd3;
    #1;
    chk("fwd2_miss", 32'(fwd2_hit), 0);
    // In-flight request is not a forwarding source
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd3;
    bus.in_data  = 32'h3333;
    #1;
    chk("fwd2_ignores_input", 32'(fwd2_hit), 0);
    bus.in_valid = 1'b0;
    bus.wb_stall = 1'b0;
    step();
    chk("fwd_after_pop1", fwd1_data, 32'h2);
    step();
    step();
    chk("fwd_after_drain", 32'(fwd1_hit), 0);
    chk("fwd_count_drained", 32'(count), 0);

    // rd==0 request is swallowed
    push(5'd0, 32'hFFFF_FFFF, 1);
    chk("rd0_count", 32'(count), 0);
    chk("rd0_regwrite", 32'(bus.RegWrite), 0);
    step();
    chk("rd0_count_later", 32'(count), 0);

    // Full, stall released with in_valid held
    bus.wb_stall = 1'b1;
    push(5'd10, 32'hA0, 1);
    push(5'd11, 32'hB0, 1);
    push(5'd12, 32'hC0, 1);
    push(5'd13, 32'hD0, 1);
    bus.wb_stall = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd14;
    bus.in_data  = 32'hE0;
    #1;
    chk("fullrel_in_ready", 32'(bus.in_ready), 0);
    step();
    chk("fullrel_count", 32'(count), 3);
    chk("fullrel_in_ready_next", 32'(bus.in_ready), 1);
    sb.push_back('{rd: 5'd14, data: 32'hE0});
    step();
    bus.in_valid = 1'b0;
    chk("fullrel_pushpop_count", 32'(count), 3);
    repeat (6) step();
    chk("fullrel_drained", 32'(count), 0);

    // Reset mid-operation discards pending entries
    bus.wb_stall = 1'b1;
    push(5'd20, 32'h20, 1);
    push(5'd21, 32'h21, 1);
    push(5'd22, 32'h22, 1);
    chk("midrst_count_pre", 32'(count), 3);
    R1 = 5'd20;
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_regwrite", 32'(bus.RegWrite), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_fwd1_hit", 32'(fwd1_hit), 0);
    bus.wb_stall = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("midrst_count_post", 32'(count), 0);
    chk("midrst_w1_post", 32'(bus.W1), 0);

    @(negedge clk);
    chk("sb_empty_at_end", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
